receive_uart_rx_decoder: RTL and testbench
==========================================

# receive_uart_rx_decoder

Master-side UART receiver that pairs with the slave board's collision-event transmitter. It deserializes 8N1 frames at BAUD_RATE using 16x oversampling and mid-bit sampling. It then decodes the event byte codes 0x41–0x46 into one-clock event pulses for the master game logic. Malformed frames and unknown codes are flagged rather than dropped silently.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate; oversample tick period BAUD_COUNT = (CLK_FREQ/BAUD_RATE)/16 clocks (651 at defaults).
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_rx  input  1  serial line, idle high, asynchronous to clk.
- o_rx_data  output  8  last correctly framed byte; holds until the next good frame.
- o_rx_done  output  1  one-clock pulse: a good frame was received.
- o_frame_err  output  1  one-clock pulse: stop bit sampled low.
- o_collision  output  1  pulse on byte 0x46.
- o_collision1  output  1  pulse on byte 0x41.
- o_collision2  output  1  pulse on byte 0x42.
- o_collision3  output  1  pulse on byte 0x43.
- o_collision_ending  output  1  pulse on byte 0x44.
- o_poke_rst  output  1  pulse on byte 0x45.
- o_unknown  output  1  pulse on a good frame whose byte is outside 0x41–0x46.

## Operation
- Synchronizer: i_rx passes through a 2-FF chain to produce rx_s. Both FFs reset to 1. A third register, rx_d, holds the previous rx_s for falling-edge detection.
- Tick generator: counter 0..BAUD_COUNT-1, free-running from reset. The registered tick pulses high for one clock when the counter wraps.
- FSM states: IDLE, START, DATA, STOP. The FSM resets to IDLE with tick_cnt=0, bit_cnt=0 and shift=0.
- IDLE:
  - On rx_d=1 and rx_s=0 (falling edge), clear tick_cnt and go to START.
  - A line held low never re-arms the FSM.
- START, on each tick:
  - At tick_cnt==7, mid start bit: if rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0. Otherwise treat it as a glitch and return to IDLE with no output.
  - Otherwise increment tick_cnt.
- DATA, on each tick:
  - At tick_cnt==15, set shift[bit_cnt]=rx_s (LSB first) and clear tick_cnt.
  - If bit_cnt==7, go to STOP; otherwise increment bit_cnt.
  - Otherwise increment tick_cnt.
- STOP, on each tick:
  - At tick_cnt==15: if rx_s=1, load o_rx_data=shift, pulse o_rx_done and the decoded output. If rx_s=0, pulse o_frame_err only; o_rx_data is unchanged and no event fires. Either way, go to IDLE with tick_cnt=0.
- Decode runs combinationally from shift and is registered into the pulse outputs on the STOP accept edge. At most one event output or o_unknown is asserted per frame.
- Ticks arriving in IDLE are ignored.
- Reset mid-frame aborts immediately. No partial byte is ever reported, and all outputs are 0 after reset.

## Timing
- Reset values: o_rx_data=8'h00; all pulse outputs 0; FSM in IDLE.
- Input latency: 2 clocks through the synchronizer plus 1 for edge detect.
- Sample points: the start bit is checked 8 ticks after the edge is detected. Each data bit is sampled 16 ticks after the previous sample, and the stop bit is sampled 16 ticks after bit 7.
- Total ticks from edge detection to stop sample: 8 + 8×16 + 16 = 152 ticks.
- Output latency: o_rx_done, the event pulse and o_rx_data all update on the same clock edge, one clock after the stop-sample tick. All pulses are exactly one clk wide.
- Back-to-back frames: the FSM is back in IDLE about half a bit before the stop bit ends. A start edge arriving right after the stop bit is therefore caught, with no dead frame.
- Tick-phase jitter: up to 1/16 bit of offset, tolerated against the free-running tick.

## Test plan
- Reset with reset=0, i_rx=1, then release -> all outputs 0, o_rx_data=8'h00, no pulse for 20,000 clocks.
- Send frame 0x46 at 9600 baud (10,416 clocks/bit) -> exactly one o_collision pulse together with o_rx_done; o_rx_data=8'h46; no other output pulses.
- Send 0x41, 0x42, 0x43, 0x44, 0x45 back-to-back with zero idle gap -> o_collision1, o_collision2, o_collision3, o_collision_ending, o_poke_rst pulse once each, in order; o_rx_data ends at 8'h45.
- Send 0x5A -> o_rx_done and o_unknown pulse, o_rx_data=8'h5A, no event pulse. Then send 0x41 with stop bit forced low -> o_frame_err pulse only; o_rx_data stays 8'h5A.
- Drive a 3,000-clock low glitch on idle i_rx -> FSM returns to IDLE and no output pulses. Then hold i_rx low for 2 frame times -> one o_frame_err; no further activity until i_rx returns high and falls again.
- Assert reset mid-DATA of frame 0x43 -> outputs return to 0 asynchronously. After release, a clean 0x44 frame yields a single o_collision_ending pulse.

Source files
------------

// File: rtl/receive_uart_rx_decoder_if.sv
// Serial input and decoded event outputs of the master-side UART receiver.
// The decoder sits on the slave modport; the game logic consuming events uses master.
interface receive_uart_rx_decoder_if;
    logic       i_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_collision;
    logic       o_collision1;
    logic       o_collision2;
    logic       o_collision3;
    logic       o_collision_ending;
    logic       o_poke_rst;
    logic       o_unknown;

    modport slave (
        input  i_rx,
        output o_rx_data, o_rx_done, o_frame_err, o_collision, o_collision1,
               o_collision2, o_collision3, o_collision_ending, o_poke_rst, o_unknown
    );

    modport master (
        output i_rx,
        input  o_rx_data, o_rx_done, o_frame_err, o_collision, o_collision1,
               o_collision2, o_collision3, o_collision_ending, o_poke_rst, o_unknown
    );
endinterface

// File: rtl/receive_uart_rx_decoder.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, and decoding of
// collision-event bytes 0x41..0x46 into one-clock pulses.
module receive_uart_rx_decoder #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                        clk,
    input  logic                        reset,
    receive_uart_rx_decoder_if.slave    bus
);
    localparam int BAUD_COUNT = (CLK_FREQ / BAUD_RATE) / 16;
    localparam int BW         = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta_reg, rx_s_reg, rx_d_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic          tick_reg;
    logic [1:0]    state_reg, state_next;
    logic [3:0]    tick_cnt_reg, tick_cnt_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          accept, frame_err_next;
    logic [7:0]    data_reg;
    logic          done_reg, err_reg, unknown_reg;
    logic [5:0]    ev_reg;
    logic [5:0]    code_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_d_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= bus.i_rx;
            rx_s_reg    <= rx_meta_reg;
            rx_d_reg    <= rx_s_reg;
        end
    end

    // Free-running oversample tick; never resynchronised to the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_reg <= '0;
            tick_reg     <= 1'b0;
        end else if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            tick_reg     <= 1'b1;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
            tick_reg     <= 1'b0;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        accept         = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_d_reg && !rx_s_reg) begin
                    tick_cnt_next = 4'd0;
                    state_next    = START;
                end
            end
            START: if (tick_reg) begin
                if (tick_cnt_reg == 4'd7) begin
                    tick_cnt_next = 4'd0;
                    bit_cnt_next  = 3'd0;
                    state_next    = rx_s_reg ? IDLE : DATA;
                end else begin
                    tick_cnt_next = tick_cnt_reg + 4'd1;
                end
            end
            DATA: if (tick_reg) begin
                if (tick_cnt_reg == 4'd15) begin
                    shift_next[bit_cnt_reg] = rx_s_reg;
                    tick_cnt_next           = 4'd0;
                    if (bit_cnt_reg == 3'd7) state_next = STOP;
                    else                     bit_cnt_next = bit_cnt_reg + 3'd1;
                end else begin
                    tick_cnt_next = tick_cnt_reg + 4'd1;
                end
            end
            default: if (tick_reg) begin
                if (tick_cnt_reg == 4'd15) begin
                    accept         = rx_s_reg;
                    frame_err_next = !rx_s_reg;
                    tick_cnt_next  = 4'd0;
                    state_next     = IDLE;
                end else begin
                    tick_cnt_next = tick_cnt_reg + 4'd1;
                end
            end
        endcase
    end

    // code_hit[gi] flags byte 0x41+gi; bit 5 (0x46) is the plain collision event.
    for (genvar gi = 0; gi < 6; gi++) begin : g_decode
        localparam logic [7:0] CODE = 8'h41 + 8'(gi);
        assign code_hit[gi] = (shift_reg == CODE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= 4'd0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            data_reg     <= 8'h00;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            ev_reg       <= 6'd0;
            unknown_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            if (accept) data_reg <= shift_reg;
            done_reg     <= accept;
            err_reg      <= frame_err_next;
            ev_reg       <= accept ? code_hit : 6'd0;
            unknown_reg  <= accept && (code_hit == 6'd0);
        end
    end

    assign bus.o_rx_data          = data_reg;
    assign bus.o_rx_done          = done_reg;
    assign bus.o_frame_err        = err_reg;
    assign bus.o_collision1       = ev_reg[0];
    assign bus.o_collision2       = ev_reg[1];
    assign bus.o_collision3       = ev_reg[2];
    assign bus.o_collision_ending = ev_reg[3];
    assign bus.o_poke_rst         = ev_reg[4];
    assign bus.o_collision        = ev_reg[5];
    assign bus.o_unknown          = unknown_reg;
endmodule

// File: tb/tb_receive_uart_rx_decoder.sv
// Directed bench for receive_uart_rx_decoder at a scaled-down line rate
// (64 clocks per bit) so that complete frames fit in a short run.
module tb_receive_uart_rx_decoder;
    localparam int CLK_FREQ  = 6_400_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BIT       = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    receive_uart_rx_decoder_if bus();

    receive_uart_rx_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ev bit order: 0=collision(46) 1=c1(41) 2=c2(42) 3=c3(43) 4=ending(44) 5=poke(45) 6=unknown
    typedef struct packed {
        logic [7:0] data;
        logic       done;
        logic       err;
        logic [6:0] ev;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic [7:0] exp_data;
        logic       exp_done;
        logic       exp_err;
        logic [6:0] exp_ev;
    } vec_t;

    rec_t recs[$];
    int   wide_cnt = 0;
    logic prev_any = 1'b0;

    wire [6:0] ev_now = {bus.o_unknown, bus.o_poke_rst, bus.o_collision_ending,
                         bus.o_collision3, bus.o_collision2, bus.o_collision1, bus.o_collision};
    wire any_now = bus.o_rx_done | bus.o_frame_err | (|ev_now);

    always @(negedge clk) begin
        if (any_now) recs.push_back('{bus.o_rx_data, bus.o_rx_done, bus.o_frame_err, ev_now});
        if (any_now && prev_any) wide_cnt++;
        prev_any = any_now;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        bus.i_rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.i_rx = b[i];
            wait_clks(BIT);
        end
        bus.i_rx = stop_ok;
        wait_clks(BIT);
        bus.i_rx = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h46, 1'b1, 8'h46, 1'b1, 1'b0, 7'b0000001};
        vecs[1] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 7'b1000000};
        vecs[2] = '{8'h41, 1'b0, 8'h5A, 1'b0, 1'b1, 7'b0000000};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 7'b1000000};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 7'b1000000};
        vecs[5] = '{8'h47, 1'b1, 8'h47, 1'b1, 1'b0, 7'b1000000};
        vecs[6] = '{8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 7'b1000000};
        vecs[7] = '{8'h45, 1'b1, 8'h45, 1'b1, 1'b0, 7'b0100000};

        bus.i_rx = 1'b1;
        wait_clks(20);
        chk("reset_data", 32'(bus.o_rx_data), 32'h00);
        chk("reset_pulses", 32'(any_now), 32'd0);
        reset = 1'b1;
        wait_clks(2000);
        chk("idle_no_pulse", 32'(recs.size()), 32'd0);
        chk("idle_data", 32'(bus.o_rx_data), 32'h00);
        $display("reset/idle: records=%0d data=%02h", recs.size(), bus.o_rx_data);

        foreach (vecs[v]) begin
            recs.delete();
            send_frame(vecs[v].data, vecs[v].stop_ok);
            wait_clks(BIT);
            chk($sformatf("vec%0d_count", v), 32'(recs.size()), 32'd1);
            if (recs.size() >= 1) begin
                chk($sformatf("vec%0d_data", v), 32'(recs[0].data), 32'(vecs[v].exp_data));
                chk($sformatf("vec%0d_done", v), 32'(recs[0].done), 32'(vecs[v].exp_done));
                chk($sformatf("vec%0d_err", v),  32'(recs[0].err),  32'(vecs[v].exp_err));
                chk($sformatf("vec%0d_ev", v),   32'(recs[0].ev),   32'(vecs[v].exp_ev));
                $display("frame %02h stop=%0b: data=%02h done=%0b err=%0b ev=%07b",
                         vecs[v].data, vecs[v].stop_ok, recs[0].data, recs[0].done,
                         recs[0].err, recs[0].ev);
            end
        end

        // Back-to-back 0x41..0x45 with no idle gap between stop and next start.
        recs.delete();
        for (int k = 0; k < 5; k++) begin
            logic [7:0] b;
            b = 8'h41 + 8'(k);
            send_frame(b, 1'b1);
        end
        wait_clks(BIT);
        chk("b2b_count", 32'(recs.size()), 32'd5);
        for (int k = 0; k < 5 && k < recs.size(); k++) begin
            chk($sformatf("b2b%0d_ev", k), 32'(recs[k].ev), 32'(7'b1 << (k + 1)));
            chk($sformatf("b2b%0d_data", k), 32'(recs[k].data), 32'h41 + 32'(k));
            $display("b2b frame %0d: data=%02h ev=%07b", k, recs[k].data, recs[k].ev);
        end
        chk("b2b_final_data", 32'(bus.o_rx_data), 32'h45);

        // Short low glitch shorter than half a bit.
        recs.delete();
        bus.i_rx = 1'b0;
        wait_clks(20);
        bus.i_rx = 1'b1;
        wait_clks(1000);
        chk("glitch_no_pulse", 32'(recs.size()), 32'd0);
        $display("glitch: records=%0d", recs.size());

        // Line stuck low: one framing error, then silence until a new falling edge.
        bus.i_rx = 1'b0;
        wait_clks(20 * BIT);
        chk("stuck_count", 32'(recs.size()), 32'd1);
        if (recs.size() >= 1) begin
            chk("stuck_err", 32'(recs[0].err), 32'd1);
            chk("stuck_done", 32'(recs[0].done), 32'd0);
            chk("stuck_ev", 32'(recs[0].ev), 32'd0);
            chk("stuck_data", 32'(recs[0].data), 32'h45);
        end
        bus.i_rx = 1'b1;
        wait_clks(20 * BIT);
        chk("stuck_release_quiet", 32'(recs.size()), 32'd1);
        send_frame(8'h42, 1'b1);
        wait_clks(BIT);
        chk("rearm_count", 32'(recs.size()), 32'd2);
        if (recs.size() >= 2) begin
            chk("rearm_ev", 32'(recs[1].ev), 32'(7'b0000100));
            chk("rearm_data", 32'(recs[1].data), 32'h42);
        end
        $display("stuck-low then 42: records=%0d data=%02h", recs.size(), bus.o_rx_data);

        // Reset asserted mid-DATA of 0x43; held until the line is idle again.
        recs.delete();
        fork
            send_frame(8'h43, 1'b1);
            begin
                wait_clks(4 * BIT + 10);
                reset = 1'b0;
                #3;
                chk("async_rst_data", 32'(bus.o_rx_data), 32'h00);
                chk("async_rst_pulses", 32'(any_now), 32'd0);
            end
        join
        wait_clks(10);
        reset = 1'b1;
        wait_clks(100);
        chk("rst_abort_no_pulse", 32'(recs.size()), 32'd0);
        send_frame(8'h44, 1'b1);
        wait_clks(BIT);
        chk("post_rst_count", 32'(recs.size()), 32'd1);
        if (recs.size() >= 1) begin
            chk("post_rst_ev", 32'(recs[0].ev), 32'(7'b0010000));
            chk("post_rst_data", 32'(recs[0].data), 32'h44);
            chk("post_rst_done", 32'(recs[0].done), 32'd1);
        end
        $display("reset mid-frame then 44: records=%0d data=%02h", recs.size(), bus.o_rx_data);

        chk("pulse_width", 32'(wide_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
